mult33_accum: RTL
=================

Name: mult33_accum

Overview:
- Downstream consumer of the 33x33 Karatsuba multiplier's 66-bit product.
- Sums a group of products (dot product / multiply-accumulate) and presents each finished group sum through a valid/ready output register.
- Drives a registered operand-issue enable back to the multiplier feeder. The feeder must honour it, because the multiplier's one-cycle latency leaves one product in flight.

Parameters:
- ACC_W, 74, accumulator and sum width in bits. Must be at least 66; 74 allows 256 full-scale products.
- CNT_W, 8, width of the per-group product counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- prod_in  input  66  product from the multiplier.
- prod_valid  input  1  prod_in valid this cycle; delayed one cycle from operand issue.
- prod_last  input  1  prod_in closes the current group; qualified by prod_valid.
- op_ready  output  1  registered; the feeder may issue operands to the multiplier only in cycles where this is 1.
- sum_out  output  ACC_W  finished group sum.
- sum_cnt  output  CNT_W  number of products in the group, saturating at all-ones.
- sum_ovf  output  1  the group's accumulation wrapped past 2^ACC_W.
- sum_valid  output  1  sum_out/sum_cnt/sum_ovf valid; held until accepted.
- sum_ready  input  1  consumer accepts the sum when sum_valid&&sum_ready.
- proto_err  output  1  sticky: product arrived while the skid was full.

Behaviour:
- Reset (async, reset=0): acc=0, cnt=0, ovf=0, skid empty, state=ACCUM, op_ready=0, sum_valid=0, sum_out=0, sum_cnt=0, sum_ovf=0, proto_err=0.
  - op_ready rises on the first clk edge after reset deasserts.
  - A reset mid-group discards all partial state; no sum is emitted.
- out_free = !sum_valid || sum_ready, evaluated combinationally in the current cycle.
- Effective input each cycle: the skid entry if the skid is valid, otherwise prod_in/prod_valid/prod_last.
- Arithmetic:
  - nacc = acc + zero-extended input, modulo 2^ACC_W.
  - ovf accumulates the carry-out of each add.
  - cnt increments per product and saturates.
- State ACCUM:
  - Input valid and not last: acc<=nacc, cnt++, ovf updated.
  - Input last and out_free: sum_out<=nacc, sum_cnt<=cnt+1 (saturated), sum_ovf<=ovf|carry, sum_valid<=1 next cycle. Then acc<=0, cnt<=0, ovf<=0.
  - Input last and not out_free: acc<=nacc (finished), cnt and ovf updated, go to PEND.
  - Single-product group (last on the first product) is legal; sum = zero-extended product, cnt=1.
- State PEND (acc holds a finished sum):
  - A prod_valid arriving while the skid is empty is captured into the skid together with its last bit. This covers the one product issued in the cycle op_ready was still 1.
  - prod_valid while the skid is full: product dropped, proto_err<=1 (sticky until reset).
  - When out_free: sum_out<=acc, sum_cnt<=cnt, sum_ovf<=ovf, sum_valid<=1. Then acc/cnt/ovf<=0, go to ACCUM.
  - A skid entry present at that point is consumed as the input on the next ACCUM cycle.
- Output register: sum_valid drops on acceptance unless a new sum loads in the same cycle (back-to-back sums allowed). Contents are stable while sum_valid && !sum_ready.
- op_ready next value = (next_state==ACCUM) && skid empty next cycle.
- Latency: last product at cycle t with out_free gives sum_valid=1 at t+1. Sustained throughput is one product per cycle with no bubbles while sum_ready stays 1.
- In ACCUM, prod_valid coinciding with a valid skid entry is a protocol error (proto_err<=1, prod_in dropped). It cannot occur when the feeder honours op_ready.

Test Plan:
- Reset, then feed products 3, 5, 7 (last on 7), sum_ready=1 -> sum_out=15, sum_cnt=3, sum_ovf=0, sum_valid high exactly one cycle, one cycle after the last product.
- Single product 2^66-1 with last -> sum_out=2^66-1, sum_cnt=1; then a second group of 1, 1 -> sum_out=2, with sum_valid on consecutive groups and no gap.
- Hold sum_ready=0 with group A=10 pending, then close group B=4+6 with one in-flight product 9 arriving after op_ready drops -> state PEND, skid holds 9, op_ready=0. Raise sum_ready -> A=10 accepted, then B=10 presented, then 9 accumulates into group C.
- ACC_W=67: accumulate 2^66-1 four times with last -> sum_out=(4*(2^66-1)) mod 2^67, sum_ovf=1, cnt=4.
- Pulse reset low mid-group after 2 products -> all outputs 0 immediately (asynchronously); a new group 8 after reset gives sum_out=8, cnt=1.
- In PEND with the skid full, drive prod_valid -> proto_err=1 and stays 1; the skid content is unchanged.

Source files
------------

// File: rtl/mult33_accum.sv
// Multiply-accumulate back end for the 33x33 multiplier: sums product groups and
// presents each finished group through a valid/ready output register.
module mult33_accum #(
  parameter int ACC_W = 74,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [65:0]      prod_in,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             op_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] sum_cnt,
  output logic             sum_ovf,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             proto_err
);

  typedef enum logic {ACCUM = 1'b0, PEND = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             skid_vld_q, skid_vld_d;
  logic             skid_last_q, skid_last_d;
  logic [65:0]      skid_data_q, skid_data_d;
  logic [ACC_W-1:0] sum_out_q, sum_out_d;
  logic [CNT_W-1:0] sum_cnt_q, sum_cnt_d;
  logic             sum_ovf_q, sum_ovf_d;
  logic             sum_valid_q, sum_valid_d;
  logic             proto_err_q, proto_err_d;
  logic             op_ready_q, op_ready_d;

  logic             out_free;
  logic             in_vld, in_last;
  logic [65:0]      in_data;
  logic [ACC_W:0]   add;
  logic [ACC_W-1:0] nacc;
  logic             carry;
  logic [CNT_W-1:0] ncnt;

  // A held skid entry takes priority over the live product input.
  always_comb begin
    out_free = !sum_valid_q || sum_ready;
    in_vld   = skid_vld_q ? 1'b1 : prod_valid;
    in_last  = skid_vld_q ? skid_last_q : prod_last;
    in_data  = skid_vld_q ? skid_data_q : prod_in;
    add      = {1'b0, acc_q} + {{(ACC_W + 1 - 66){1'b0}}, in_data};
    nacc     = add[ACC_W-1:0];
    carry    = add[ACC_W];
    ncnt     = sat_inc(cnt_q);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    sum_out_d   = sum_out_q;
    sum_cnt_d   = sum_cnt_q;
    sum_ovf_d   = sum_ovf_q;
    sum_valid_d = sum_valid_q && !sum_ready;
    proto_err_d = proto_err_q;

    case (state_q)
      ACCUM: begin
        if (skid_vld_q) begin
          skid_vld_d = 1'b0;
          if (prod_valid) proto_err_d = 1'b1;
        end
        if (in_vld) begin
          if (in_last && out_free) begin
            sum_out_d   = nacc;
            sum_cnt_d   = ncnt;
            sum_ovf_d   = ovf_q | carry;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end else begin
            acc_d = nacc;
            cnt_d = ncnt;
            ovf_d = ovf_q | carry;
            if (in_last) state_d = PEND;
          end
        end
      end
      PEND: begin
        // Catches the single product issued while op_ready was still high.
        if (prod_valid) begin
          if (!skid_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_last_d = prod_last;
            skid_data_d = prod_in;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        if (out_free) begin
          sum_out_d   = acc_q;
          sum_cnt_d   = cnt_q;
          sum_ovf_d   = ovf_q;
          sum_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    op_ready_d = (state_d == ACCUM) && !skid_vld_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      sum_out_q   <= '0;
      sum_cnt_q   <= '0;
      sum_ovf_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
      op_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
      sum_out_q   <= sum_out_d;
      sum_cnt_q   <= sum_cnt_d;
      sum_ovf_q   <= sum_ovf_d;
      sum_valid_q <= sum_valid_d;
      proto_err_q <= proto_err_d;
      op_ready_q  <= op_ready_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign sum_out   = sum_out_q;
  assign sum_cnt   = sum_cnt_q;
  assign sum_ovf   = sum_ovf_q;
  assign sum_valid = sum_valid_q;
  assign proto_err = proto_err_q;

endmodule
